// File: rtl/cordic_cos_arbiter.sv
// Two-requester front end for a free-running, fixed-latency cosine CORDIC pipeline.
// Round-robin issue is gated by per-requester credits so results never overflow the response FIFOs.
module cordic_cos_arbiter #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_angle,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_angle,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              cordic_clk_en,
    output logic              cordic_reset,
    output logic [DATA_W-1:0] cordic_angle,
    input  logic [DATA_W-1:0] cordic_result,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]         vld, elig, ready, grant, wr, pop, rvld;
    logic               both;
    logic               rr_q, rr_d;
    logic [LATENCY-1:0] tag_vld_q, tag_id_q;
    logic [CW-1:0]      cnt_q [2];
    logic [CW-1:0]      cnt_d [2];
    logic [CW-1:0]      fcnt_q [2];
    logic [CW-1:0]      fcnt_d [2];
    logic [PW-1:0]      wp_q [2];
    logic [PW-1:0]      wp_d [2];
    logic [PW-1:0]      rp_q [2];
    logic [PW-1:0]      rp_d [2];
    logic [DATA_W-1:0]  mem_q [2][DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign vld = {req1_valid, req0_valid};

    // Credits cover in-flight ops plus buffered results, so an issued op always has a FIFO slot.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            elig[k] = !reset && (cnt_q[k] < DEPTH_C);
        end
        both     = &(vld & elig);
        ready[0] = elig[0] && (!rr_q || !both);
        ready[1] = elig[1] && (rr_q || !both);
        grant    = vld & ready;
        rr_d     = grant[0] ? 1'b1 : (grant[1] ? 1'b0 : rr_q);
    end

    assign req0_ready    = ready[0];
    assign req1_ready    = ready[1];
    assign cordic_angle  = grant[0] ? req0_angle : (grant[1] ? req1_angle : '0);
    assign cordic_reset  = reset;
    assign cordic_clk_en = !reset;

    assign wr[0] = tag_vld_q[LATENCY-1] && !tag_id_q[LATENCY-1];
    assign wr[1] = tag_vld_q[LATENCY-1] && tag_id_q[LATENCY-1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rvld[k] = (fcnt_q[k] != '0);
        end
    end

    assign pop        = rvld & {rsp1_ready, rsp0_ready};
    assign rsp0_valid = rvld[0];
    assign rsp1_valid = rvld[1];
    assign rsp0_data  = mem_q[0][rp_q[0]];
    assign rsp1_data  = mem_q[1][rp_q[1]];
    assign busy       = (|tag_vld_q) || (|rvld);

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = cnt_q[k];
            if (grant[k] && !pop[k]) begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end else if (!grant[k] && pop[k]) begin
                cnt_d[k] = cnt_q[k] - CW'(1);
            end
            fcnt_d[k] = fcnt_q[k];
            if (wr[k] && !pop[k]) begin
                fcnt_d[k] = fcnt_q[k] + CW'(1);
            end else if (!wr[k] && pop[k]) begin
                fcnt_d[k] = fcnt_q[k] - CW'(1);
            end
            wp_d[k] = wr[k] ? ptr_inc(wp_q[k]) : wp_q[k];
            rp_d[k] = pop[k] ? ptr_inc(rp_q[k]) : rp_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q      <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k]  <= '0;
                fcnt_q[k] <= '0;
                wp_q[k]   <= '0;
                rp_q[k]   <= '0;
            end
        end else begin
            rr_q      <= rr_d;
            tag_vld_q <= {tag_vld_q[LATENCY-2:0], |grant};
            tag_id_q  <= {tag_id_q[LATENCY-2:0], grant[1]};
            for (int k = 0; k < 2; k++) begin
                cnt_q[k]  <= cnt_d[k];
                fcnt_q[k] <= fcnt_d[k];
                wp_q[k]   <= wp_d[k];
                rp_q[k]   <= rp_d[k];
            end
        end
    end

    // Result storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr[k]) begin
                mem_q[k][wp_q[k]] <= cordic_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                assert (!(wr[k] && (fcnt_q[k] == DEPTH_C)));
            end
        end
    end
endmodule

// File: tb/tb_cordic_cos_arbiter.sv
// Directed bench for cordic_cos_arbiter with a behavioural 4-register cosine pipeline
// that returns exact float32 words for the test angles.
module tb_cordic_cos_arbiter;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 4;
    localparam logic [31:0] ANG_0   = 32'h00000000;
    localparam logic [31:0] ANG_PI3 = 32'h3F860A92;
    localparam logic [31:0] COS_0   = 32'h3F800000;
    localparam logic [31:0] COS_PI3 = 32'h3F000000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_angle = '0, req1_angle = '0;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic              cordic_clk_en, cordic_reset, busy;
    logic [DATA_W-1:0] cordic_angle, cordic_result;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_cos_arbiter #(.DATA_W(DATA_W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_angle(req0_angle),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_angle(req1_angle),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .cordic_clk_en(cordic_clk_en), .cordic_reset(cordic_reset),
        .cordic_angle(cordic_angle), .cordic_result(cordic_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cos_model(input logic [31:0] a);
        case (a)
            ANG_0:   return COS_0;
            ANG_PI3: return COS_PI3;
            default: return 32'h7FC00000;
        endcase
    endfunction

    // Input register plus three stages; stages clear when clk_en drops.
    logic [31:0] pipe [LATENCY];
    assign cordic_result = pipe[LATENCY-1];
    always @(posedge clk) begin
        if (cordic_reset || !cordic_clk_en) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= cos_model(cordic_angle);
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_angle = '0;   req1_angle = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        req0_valid = 1'b1; req0_angle = ANG_PI3;
        #1;
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
        n_tests++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid}); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (cordic_angle !== 32'h0) begin n_fail++; $display("FAIL reset_cordic_angle: got %h want 0", cordic_angle); end
        n_tests++; if ({cordic_reset, cordic_clk_en} !== 2'b10) begin n_fail++; $display("FAIL reset_pipe_ctl: got %b want 10", {cordic_reset, cordic_clk_en}); end
        reset = 1'b0;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req0_ready: got %b want 1", req0_ready); end
        n_tests++; if ({cordic_reset, cordic_clk_en} !== 2'b01) begin n_fail++; $display("FAIL post_reset_pipe_ctl: got %b want 01", {cordic_reset, cordic_clk_en}); end
        idle();
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1'b1; req0_angle = ANG_0;
        #1;
        n_tests++; if ({req1_ready, req0_ready} !== 2'b11) begin n_fail++; $display("FAIL single_ready: got %b want 11", {req1_ready, req0_ready}); end
        tick();
        req0_valid = 1'b0;
        for (int c = 1; c <= LATENCY; c++) begin
            tick();
            n_tests++; if (rsp0_valid !== (c == LATENCY)) begin n_fail++; $display("FAIL single_rsp0_valid c=%0d: got %b want %b", c, rsp0_valid, (c == LATENCY)); end
            n_tests++; if (rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp1_valid c=%0d: got %b want 0", c, rsp1_valid); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy c=%0d: got %b want 1", c, busy); end
        end
        n_tests++; if (rsp0_data !== COS_0) begin n_fail++; $display("FAIL single_rsp0_data: got %h want %h", rsp0_data, COS_0); end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        n_tests++; if ({busy, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL single_drained: got busy,valid=%b want 00", {busy, rsp0_valid}); end
    endtask

    task automatic test_alternation();
        int got0 = 0;
        int got1 = 0;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_angle = ANG_PI3;
        req1_valid = 1'b1; req1_angle = ANG_0;
        for (int i = 0; i < 14; i++) begin
            if (i == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (i < 8) begin
                n_tests++; if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_grant i=%0d: got %b want %b", i, {req1_ready, req0_ready}, ((i % 2 == 0) ? 2'b01 : 2'b10)); end
                n_tests++; if (cordic_angle !== ((i % 2 == 0) ? ANG_PI3 : ANG_0)) begin n_fail++; $display("FAIL alt_angle i=%0d: got %h", i, cordic_angle); end
            end
            if (rsp0_valid) begin
                got0++;
                n_tests++; if (rsp0_data !== COS_PI3) begin n_fail++; $display("FAIL alt_rsp0_data: got %h want %h", rsp0_data, COS_PI3); end
            end
            if (rsp1_valid) begin
                got1++;
                n_tests++; if (rsp1_data !== COS_0) begin n_fail++; $display("FAIL alt_rsp1_data: got %h want %h", rsp1_data, COS_0); end
            end
            tick();
        end
        n_tests++; if (got0 !== 4) begin n_fail++; $display("FAIL alt_rsp0_count: got %0d want 4", got0); end
        n_tests++; if (got1 !== 4) begin n_fail++; $display("FAIL alt_rsp1_count: got %0d want 4", got1); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_angle = ANG_0;
        req1_valid = 1'b1; req1_angle = ANG_0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_tests++; if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL bp_share i=%0d: got %b want %b", i, {req1_ready, req0_ready}, ((i % 2 == 0) ? 2'b01 : 2'b10)); end
            tick();
        end
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_blocked i=%0d: got %b want 0", i, req0_ready); end
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        n_tests++; if ({rsp0_valid, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got valid,ready=%b want 10", {rsp0_valid, req0_ready}); end
        tick();
        rsp0_ready = 1'b0;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reissue: got %b want 1", req0_ready); end
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_one_only i=%0d: got %b want 0", i, req0_ready); end
            tick();
        end
    endtask

    task automatic test_simul_issue_pop();
        do_reset();
        req0_valid = 1'b1; req0_angle = ANG_0;
        for (int i = 0; i < 3; i++) tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++; if (dut.cnt_q[0] !== 3'd3) begin n_fail++; $display("FAIL sim_cnt_before: got %0d want 3", dut.cnt_q[0]); end
        req0_valid = 1'b1; rsp0_ready = 1'b1;
        #1;
        n_tests++; if ({rsp0_valid, req0_ready} !== 2'b11) begin n_fail++; $display("FAIL sim_ready_before: got valid,ready=%b want 11", {rsp0_valid, req0_ready}); end
        tick();
        n_tests++; if (dut.cnt_q[0] !== 3'd3) begin n_fail++; $display("FAIL sim_cnt_after: got %0d want 3", dut.cnt_q[0]); end
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL sim_ready_after: got %b want 1", req0_ready); end
        idle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req1_valid = 1'b1; req1_angle = ANG_0; rsp1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL mid_issue i=%0d: got %b want 1", i, req1_ready); end
            tick();
        end
        req1_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 0", req1_ready); end
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (dut.cnt_q[1] !== 3'd0) begin n_fail++; $display("FAIL mid_cnt1: got %0d want 0", dut.cnt_q[1]); end
        n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_after: got %b want 1", req1_ready); end
        for (int c = 0; c < 8; c++) begin
            #1;
            n_tests++; if ({busy, rsp1_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_quiet c=%0d: got busy,valid=%b want 00", c, {busy, rsp1_valid}); end
            tick();
        end
    endtask

    task automatic test_ordering();
        do_reset();
        req0_valid = 1'b1; req0_angle = ANG_0;
        tick();
        req0_angle = ANG_PI3;
        #1;
        n_tests++; if ({req0_ready, cordic_angle} !== {1'b1, ANG_PI3}) begin n_fail++; $display("FAIL ord_second_issue: got %b/%h", req0_ready, cordic_angle); end
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_tests++; if ({rsp0_valid, rsp0_data} !== {1'b1, COS_0}) begin n_fail++; $display("FAIL ord_first: got %b/%h want 1/%h", rsp0_valid, rsp0_data, COS_0); end
        rsp0_ready = 1'b1;
        tick();
        n_tests++; if ({rsp0_valid, rsp0_data} !== {1'b1, COS_PI3}) begin n_fail++; $display("FAIL ord_second: got %b/%h want 1/%h", rsp0_valid, rsp0_data, COS_PI3); end
        tick();
        n_tests++; if ({busy, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL ord_drained: got busy,valid=%b want 00", {busy, rsp0_valid}); end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_alternation();
        test_backpressure();
        test_simul_issue_pop();
        test_reset_midflight();
        test_ordering();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
